// File: rtl/sh4a_decode_queue_pkg.sv
// Shared types for the SH-4A decode queue: decode record, opcode classes,
// class predicates, pairing rule and access-size scale shifts.
package sh4a_decode_queue_pkg;

  localparam int unsigned SH_B = 0;
  localparam int unsigned SH_W = 1;
  localparam int unsigned SH_L = 2;

  typedef enum logic [4:0] {
    OP_UNK, OP_NOP, OP_ALU, OP_MEM, OP_PCREL,
    OP_BRA, OP_BSR, OP_BRAF, OP_BSRF, OP_JMP, OP_JSR, OP_RTS, OP_RTE,
    OP_BT, OP_BF, OP_BTS, OP_BFS,
    OP_SLEEP, OP_LDTLB, OP_SYNCO, OP_LDCSR, OP_STCSR
  } op_e;

  typedef struct packed {
    op_e             op;
    logic            legal;
    logic            privileged;
    logic [2:0]      src_vld;
    logic [2:0][3:0] src_reg;
    logic            dest_vld;
    logic [3:0]      dest_reg;
    logic            imm_vld;
    logic [31:0]     imm;
    logic [31:0]     pc;
    logic            is_branch;
    logic            in_slot;
    logic            illegal_slot;
    logic            priv_violation;
  } sh4a_dec_t;

  function automatic logic op_serialising(op_e op);
    return op inside {OP_RTE, OP_SLEEP, OP_LDTLB, OP_SYNCO, OP_LDCSR, OP_STCSR};
  endfunction

  function automatic logic op_delayed(op_e op);
    return op inside {OP_BRA, OP_BSR, OP_BRAF, OP_BSRF, OP_JMP, OP_JSR,
                      OP_RTS, OP_RTE, OP_BTS, OP_BFS};
  endfunction

  function automatic logic op_branch(op_e op);
    return op_delayed(op) || (op inside {OP_BT, OP_BF});
  endfunction

  function automatic logic op_priv(op_e op);
    return op inside {OP_RTE, OP_SLEEP, OP_LDTLB, OP_LDCSR, OP_STCSR};
  endfunction

  function automatic logic op_pcrel(op_e op);
    return op == OP_PCREL;
  endfunction

  // b may follow a in the same issue group
  function automatic logic can_pair(sh4a_dec_t a, sh4a_dec_t b);
    logic hazard;
    hazard = 1'b0;
    for (int s = 0; s < 3; s++)
      if (a.dest_vld && b.src_vld[s] && (b.src_reg[s] == a.dest_reg)) hazard = 1'b1;
    return !op_serialising(a.op) && !hazard && !op_delayed(b.op);
  endfunction

endpackage

// File: rtl/sh4a_decode_queue_lane.sv
// Combinational single-insn decoder: 16-bit SH-4A opcode + PC -> decode record.
// Slot and privilege-violation fields are filled in by the queue.
module sh4a_decode_queue_lane
  import sh4a_decode_queue_pkg::*;
(
  input  logic [15:0] insn_i,
  input  logic [31:0] pc_i,
  output sh4a_dec_t   dec_o
);

  logic [3:0]  rn, rm;
  logic [31:0] sext8, zd4, zd8, sd12;

  assign rn    = insn_i[11:8];
  assign rm    = insn_i[7:4];
  assign sext8 = {{24{insn_i[7]}}, insn_i[7:0]};
  assign zd4   = {28'h0, insn_i[3:0]};
  assign zd8   = {24'h0, insn_i[7:0]};
  assign sd12  = {{19{insn_i[11]}}, insn_i[11:0], 1'b0};

  always_comb begin
    dec_o       = '0;
    dec_o.op    = OP_UNK;
    dec_o.legal = 1'b1;
    dec_o.pc    = pc_i;
    casez (insn_i)
      16'h0009: dec_o.op = OP_NOP;
      16'h000B: dec_o.op = OP_RTS;
      16'h002B: dec_o.op = OP_RTE;
      16'h001B: dec_o.op = OP_SLEEP;
      16'h0038: dec_o.op = OP_LDTLB;
      16'h00AB: dec_o.op = OP_SYNCO;
      16'h0?02: begin dec_o.op = OP_STCSR; dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn; end
      16'h0?23: begin dec_o.op = OP_BRAF; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rn; end
      16'h0?03: begin dec_o.op = OP_BSRF; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rn; end
      16'h4?0E: begin dec_o.op = OP_LDCSR; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rn; end
      16'h4?2B: begin dec_o.op = OP_JMP; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rn; end
      16'h4?0B: begin dec_o.op = OP_JSR; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rn; end
      16'h1???: begin
        dec_o.op = OP_MEM; dec_o.src_vld[1:0] = 2'b11; dec_o.src_reg[0] = rm; dec_o.src_reg[1] = rn;
        dec_o.imm_vld = 1'b1; dec_o.imm = zd4 << SH_L;
      end
      16'h2??2: begin
        dec_o.op = OP_MEM; dec_o.src_vld[1:0] = 2'b11; dec_o.src_reg[0] = rm; dec_o.src_reg[1] = rn;
      end
      16'h3??C: begin
        dec_o.op = OP_ALU; dec_o.src_vld[1:0] = 2'b11; dec_o.src_reg[0] = rm; dec_o.src_reg[1] = rn;
        dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn;
      end
      16'h5???: begin
        dec_o.op = OP_MEM; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rm;
        dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn; dec_o.imm_vld = 1'b1; dec_o.imm = zd4 << SH_L;
      end
      16'h6??3: begin
        dec_o.op = OP_ALU; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rm;
        dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn;
      end
      16'h7???: begin
        dec_o.op = OP_ALU; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rn;
        dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn; dec_o.imm_vld = 1'b1; dec_o.imm = sext8;
      end
      // MOV.B/W R0,@(disp,Rn)
      16'b1000_000?_????_????: begin
        dec_o.op = OP_MEM; dec_o.src_vld[1:0] = 2'b11; dec_o.src_reg[0] = 4'd0; dec_o.src_reg[1] = rm;
        dec_o.imm_vld = 1'b1; dec_o.imm = zd4 << (insn_i[8] ? SH_W : SH_B);
      end
      16'b1000_010?_????_????: begin
        dec_o.op = OP_MEM; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = rm;
        dec_o.dest_vld = 1'b1; dec_o.dest_reg = 4'd0;
        dec_o.imm_vld = 1'b1; dec_o.imm = zd4 << (insn_i[8] ? SH_W : SH_B);
      end
      16'h88??: begin
        dec_o.op = OP_ALU; dec_o.src_vld[0] = 1'b1; dec_o.src_reg[0] = 4'd0;
        dec_o.imm_vld = 1'b1; dec_o.imm = sext8;
      end
      16'b1000_1??1_????_????: begin
        dec_o.op = insn_i[10] ? (insn_i[9] ? OP_BFS : OP_BTS) : (insn_i[9] ? OP_BF : OP_BT);
        dec_o.imm_vld = 1'b1; dec_o.imm = sext8 << 1;
      end
      16'h9???: begin
        dec_o.op = OP_PCREL; dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn;
        dec_o.imm_vld = 1'b1; dec_o.imm = zd8 << SH_W;
      end
      16'hA???: begin dec_o.op = OP_BRA; dec_o.imm_vld = 1'b1; dec_o.imm = sd12; end
      16'hB???: begin dec_o.op = OP_BSR; dec_o.imm_vld = 1'b1; dec_o.imm = sd12; end
      16'hC7??: begin
        dec_o.op = OP_PCREL; dec_o.dest_vld = 1'b1; dec_o.dest_reg = 4'd0;
        dec_o.imm_vld = 1'b1; dec_o.imm = zd8 << SH_L;
      end
      16'hD???: begin
        dec_o.op = OP_PCREL; dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn;
        dec_o.imm_vld = 1'b1; dec_o.imm = zd8 << SH_L;
      end
      16'hE???: begin
        dec_o.op = OP_ALU; dec_o.dest_vld = 1'b1; dec_o.dest_reg = rn;
        dec_o.imm_vld = 1'b1; dec_o.imm = sext8;
      end
      default: dec_o.legal = 1'b0;
    endcase
    dec_o.privileged = op_priv(dec_o.op);
    dec_o.is_branch  = op_branch(dec_o.op);
  end

endmodule

// File: rtl/sh4a_decode_queue.sv
// Buffered multi-lane SH-4A decode stage: circular insn queue, pairing,
// delay-slot tracking and a registered per-lane decode output.
module sh4a_decode_queue
  import sh4a_decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 sr_md_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     in_count_i,
  input  logic [16*FETCH_WIDTH-1:0]            in_insn_i,
  input  logic [31:0]                          in_pc_i,
  output logic [ISSUE_WIDTH-1:0]               out_valid_o,
  input  logic                                 out_ready_i,
  output sh4a_dec_t [ISSUE_WIDTH-1:0]          out_dec_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FETCH_WIDTH+1);

  logic [15:0]      insn_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, n_pop;
  logic [ISSUE_WIDTH-1:0] vld_q, take;
  sh4a_dec_t [ISSUE_WIDTH-1:0] raw, nxt, dec_q;
  logic             slot_q, slot_d, push, ld;

  assign in_ready_o  = cnt_q <= (AW+1)'(DEPTH - FETCH_WIDTH);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign ld          = !(|vld_q) || out_ready_i;
  assign out_valid_o = vld_q;
  assign out_dec_o   = dec_q;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
    sh4a_decode_queue_lane u_lane (
      .insn_i (insn_mem[rd_q + AW'(g)]),
      .pc_i   (pc_mem[rd_q + AW'(g)]),
      .dec_o  (raw[g])
    );
  end

  // Lanes issue in order; a lane is taken only if every earlier lane was.
  always_comb begin
    nxt            = raw;
    take           = '0;
    n_pop          = '0;
    slot_d         = slot_q;
    take[0]        = cnt_q != '0;
    nxt[0].in_slot = slot_q;
    for (int i = 1; i < ISSUE_WIDTH; i++) begin
      take[i]        = take[i-1] && (cnt_q > (AW+1)'(i)) && can_pair(raw[i-1], raw[i]);
      nxt[i].in_slot = op_delayed(raw[i-1].op);
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      nxt[i].illegal_slot   = nxt[i].in_slot && (raw[i].is_branch || op_pcrel(raw[i].op));
      nxt[i].priv_violation = raw[i].privileged && !sr_md_i;
      if (take[i]) begin
        n_pop  = n_pop + (AW+1)'(1);
        slot_d = op_delayed(raw[i].op);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      slot_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(in_count_i);
      if (ld) begin
        rd_q   <= rd_q + n_pop[AW-1:0];
        vld_q  <= take;
        slot_q <= slot_d;
      end
      cnt_q <= cnt_q + (push ? (AW+1)'(in_count_i) : '0) - (ld ? n_pop : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld) dec_q <= nxt;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (push && (CW'(i) < in_count_i)) begin
        insn_mem[wr_q + AW'(i)] <= in_insn_i[16*i +: 16];
        pc_mem[wr_q + AW'(i)]   <= in_pc_i + 32'(2*i);
      end
    end
  end

  always @(posedge clk_i)
    if (rst_ni && in_valid_i && in_ready_o)
      assert (in_count_i != '0 && in_count_i <= CW'(FETCH_WIDTH));

endmodule

// File: tb/tb_sh4a_decode_queue.sv
// Scoreboard bench for sh4a_decode_queue: directed pushes enqueue expected
// output beats; a negedge monitor compares every accepted output beat.
module tb_sh4a_decode_queue;
  import sh4a_decode_queue_pkg::*;

  localparam int OW = 76;
  typedef struct {
    logic [1:0]    vld;
    logic [OW-1:0] l0;
    logic [OW-1:0] l1;
    string         name;
  } beat_t;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, sr_md = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_ready = 1'b1;
  logic [1:0]  in_count = '0;
  logic [31:0] in_insn = '0, in_pc = '0;
  logic [1:0]  out_valid;
  sh4a_dec_t [1:0] out_dec;

  beat_t exp_q[$];
  int    total = 0, bad = 0;

  always #5 clk = ~clk;

  sh4a_decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .sr_md_i(sr_md),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_count_i(in_count),
    .in_insn_i(in_insn), .in_pc_i(in_pc), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_dec_o(out_dec)
  );

  function automatic logic [OW-1:0] obs(sh4a_dec_t d);
    return {d.legal, d.privileged, d.dest_vld, d.dest_reg, d.imm_vld, d.imm, d.pc,
            d.is_branch, d.in_slot, d.illegal_slot, d.priv_violation};
  endfunction

  function automatic logic [OW-1:0] mk(input logic lg, pr, dv, input logic [3:0] dr,
                                       input logic iv, input logic [31:0] imm, pc,
                                       input logic br, sl, il, pv);
    return {lg, pr, dv, dr, iv, imm, pc, br, sl, il, pv};
  endfunction

  function automatic logic [OW-1:0] nop(input logic [31:0] pc, input logic sl);
    return mk(1, 0, 0, 4'd0, 0, 32'h0, pc, 0, sl, 0, 0);
  endfunction

  task automatic exp_beat(input string nm, input logic [1:0] v,
                          input logic [OW-1:0] a, input logic [OW-1:0] b);
    beat_t t;
    t.vld = v; t.l0 = a; t.l1 = b; t.name = nm;
    exp_q.push_back(t);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic push(input logic [1:0] n, input logic [15:0] i0, i1, input logic [31:0] pc);
    in_valid = 1'b1; in_count = n; in_insn = {i1, i0}; in_pc = pc;
    cyc();
    in_valid = 1'b0;
  endtask

  // Monitor: one scoreboard pop per accepted output beat
  always @(negedge clk) begin : mon
    beat_t e;
    if (rst_n && out_ready && out_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got valid=%b pc0=%h want no output", out_valid, out_dec[0].pc);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (out_valid !== e.vld) begin
          bad++;
          $display("FAIL %s.valid: got %b want %b", e.name, out_valid, e.vld);
        end
        if (e.vld[0]) begin
          total++;
          if (obs(out_dec[0]) !== e.l0) begin
            bad++;
            $display("FAIL %s.lane0: got %h want %h", e.name, obs(out_dec[0]), e.l0);
          end
        end
        if (e.vld[1]) begin
          total++;
          if (obs(out_dec[1]) !== e.l1) begin
            bad++;
            $display("FAIL %s.lane1: got %h want %h", e.name, obs(out_dec[1]), e.l1);
          end
        end
      end
    end
  end

  initial begin
    idle(3);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    cyc();

    // NOP + MOV #7F,R1 pair; latency of one edge after the push edge
    exp_beat("nop_movi", 2'b11, nop(32'h1000, 0), mk(1, 0, 1, 4'd1, 1, 32'h7F, 32'h1002, 0, 0, 0, 0));
    push(2, 16'h0009, 16'hE17F, 32'h1000);
    check("lat_push_edge", 32'(out_valid), 0);
    cyc();
    check("lat_next_edge", 32'(out_valid), 3);
    idle(3);

    // RAW on R1 splits the pair
    exp_beat("raw_a", 2'b01, mk(1, 0, 1, 4'd1, 1, 32'h5, 32'h2000, 0, 0, 0, 0), '0);
    exp_beat("raw_b", 2'b01, mk(1, 0, 0, 4'd0, 0, 32'h0, 32'h2002, 0, 0, 0, 0), '0);
    push(2, 16'hE105, 16'h2112, 32'h2000);
    idle(4);

    // RTS + NOP in the same group; RTS + BRA split, BRA lands in slot
    exp_beat("rts_pair", 2'b11, mk(1, 0, 0, 4'd0, 0, 32'h0, 32'h3000, 1, 0, 0, 0), nop(32'h3002, 1));
    push(2, 16'h000B, 16'h0009, 32'h3000);
    idle(3);
    exp_beat("rts", 2'b01, mk(1, 0, 0, 4'd0, 0, 32'h0, 32'h3100, 1, 0, 0, 0), '0);
    exp_beat("bra_slot", 2'b01, mk(1, 0, 0, 4'd0, 1, 32'hFFFF_FFFC, 32'h3102, 1, 1, 1, 0), '0);
    push(2, 16'h000B, 16'hAFFE, 32'h3100);
    idle(4);
    exp_beat("slot_pend", 2'b01, nop(32'h3200, 1), '0);
    push(1, 16'h0009, 16'h0000, 32'h3200);
    idle(3);

    // RTE in user mode: privileged, violation, serialising
    sr_md = 1'b0;
    exp_beat("rte", 2'b01, mk(1, 1, 0, 4'd0, 0, 32'h0, 32'h4000, 1, 0, 0, 1), '0);
    exp_beat("rte_slot", 2'b01, nop(32'h4002, 1), '0);
    push(2, 16'h002B, 16'h0009, 32'h4000);
    idle(4);
    sr_md = 1'b1;

    // Immediate scaling and unknown opcode
    exp_beat("disp_bt", 2'b11, mk(1, 0, 1, 4'd2, 1, 32'hC, 32'h7000, 0, 0, 0, 0),
             mk(1, 0, 0, 4'd0, 1, 32'hFFFF_FFFC, 32'h7002, 1, 0, 0, 0));
    push(2, 16'h5213, 16'h89FE, 32'h7000);
    exp_beat("disp_w", 2'b11, mk(1, 0, 1, 4'd0, 1, 32'h8, 32'h7004, 0, 0, 0, 0),
             mk(1, 0, 1, 4'd1, 1, 32'hA, 32'h7006, 0, 0, 0, 0));
    push(2, 16'h8514, 16'h9105, 32'h7004);
    exp_beat("unknown", 2'b01, mk(0, 0, 0, 4'd0, 0, 32'h0, 32'h7008, 0, 0, 0, 0), '0);
    push(1, 16'hFFFD, 16'h0000, 32'h7008);
    idle(4);

    // Fill while stalled, overflow push dropped, order kept across wrap
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_beat("fill", 2'b11, nop(32'h5000 + 32'(16*k), 0), nop(32'h5002 + 32'(16*k), 0));
      push(2, 16'h0009, 16'h0009, 32'h5000 + 32'(16*k));
      if (k == 3) check("ready_two_free", 32'(in_ready), 1);
    end
    check("full_not_ready", 32'(in_ready), 0);
    push(2, 16'h0009, 16'h0009, 32'h5050);
    out_ready = 1'b1;
    idle(8);

    // Flush clears slot state and drops the concurrent push
    exp_beat("bra_pre", 2'b01, mk(1, 0, 0, 4'd0, 1, 32'hFFFF_FFFC, 32'h6000, 1, 0, 0, 0), '0);
    push(1, 16'hAFFE, 16'h0000, 32'h6000);
    idle(3);
    flush = 1'b1; in_valid = 1'b1; in_count = 2'd1; in_insn = 32'h0009; in_pc = 32'h6100;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 0);
    check("flush_ready", 32'(in_ready), 1);
    idle(2);
    check("flush_drop", 32'(out_valid), 0);
    exp_beat("post_flush", 2'b01, nop(32'h6200, 0), '0);
    push(1, 16'h0009, 16'h0000, 32'h6200);
    idle(3);

    // Flush drops a held output
    out_ready = 1'b0;
    push(2, 16'h0009, 16'h0009, 32'h6300);
    idle(2);
    check("held_flush_pre", 32'(out_valid), 3);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("held_flush", 32'(out_valid), 0);
    out_ready = 1'b1;
    idle(2);
    check("held_flush_empty", 32'(out_valid), 0);

    // Reset mid-stall drops a held output
    out_ready = 1'b0;
    push(2, 16'h0009, 16'h0009, 32'h6400);
    idle(2);
    check("held_rst_pre", 32'(out_valid), 3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("rst_stall_valid", 32'(out_valid), 0);
    check("rst_stall_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    idle(2);
    check("rst_stall_empty", 32'(out_valid), 0);

    for (int k = 0; k < 40 && exp_q.size() != 0; k++) cyc();
    check("scoreboard_drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
